// File: rtl/lcd_pkg.sv
// Shared LCD controller definitions: command opcodes, word layout, frame scheduler states.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
    localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
    localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

    localparam int unsigned DC_BIT    = 8;
    localparam int unsigned WORD_W    = 9;
    localparam int unsigned COORD_W   = 9;
    localparam int unsigned CMD_IDX_W = 4;

    localparam logic [CMD_IDX_W-1:0] CMD_LAST = 4'd10;

    localparam logic [2:0] ST_WAIT_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_CMD       = 3'd2;
    localparam logic [2:0] ST_PIX_ADDR  = 3'd3;
    localparam logic [2:0] ST_PIX_WAIT  = 3'd4;
    localparam logic [2:0] ST_PIX_SEND  = 3'd5;
    localparam logic [2:0] ST_GAP       = 3'd6;

    typedef enum logic [2:0] {
        S_WAIT_INIT = ST_WAIT_INIT,
        S_IDLE      = ST_IDLE,
        S_CMD       = ST_CMD,
        S_PIX_ADDR  = ST_PIX_ADDR,
        S_PIX_WAIT  = ST_PIX_WAIT,
        S_PIX_SEND  = ST_PIX_SEND,
        S_GAP       = ST_GAP
    } state_t;

    // Build a serializer word: dc flag on DC_BIT, payload byte below it.
    function automatic logic [WORD_W-1:0] lcd_word(input logic dc, input logic [7:0] b);
        logic [WORD_W-1:0] w;
        w         = {1'b0, b};
        w[DC_BIT] = dc;
        return w;
    endfunction

endpackage

// File: rtl/lcd_window_cmd_rom.sv
// Full-screen window setup sequence (CASET, RASET, RAMWR) indexed by cmd_idx.
module lcd_window_cmd_rom
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240
) (
    input  logic [CMD_IDX_W-1:0] cmd_idx,
    output logic [WORD_W-1:0]    cmd_word
);

    localparam logic [15:0] H_LAST = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST = 16'(V_RES - 1);

    always_comb begin
        cmd_word = '0;
        case (cmd_idx)
            4'd0:       cmd_word = lcd_word(1'b0, LCD_CMD_CASET);
            4'd1, 4'd2: cmd_word = lcd_word(1'b1, 8'h00);
            4'd3:       cmd_word = lcd_word(1'b1, H_LAST[15:8]);
            4'd4:       cmd_word = lcd_word(1'b1, H_LAST[7:0]);
            4'd5:       cmd_word = lcd_word(1'b0, LCD_CMD_RASET);
            4'd6, 4'd7: cmd_word = lcd_word(1'b1, 8'h00);
            4'd8:       cmd_word = lcd_word(1'b1, V_LAST[15:8]);
            4'd9:       cmd_word = lcd_word(1'b1, V_LAST[7:0]);
            4'd10:      cmd_word = lcd_word(1'b0, LCD_CMD_RAMWR);
            default:    cmd_word = '0;
        endcase
    end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Owns the lcd_write serializer: passes the init stream through, then repeatedly
// sets the full-screen window and streams H_RES x V_RES pixels from a pixel source.
module lcd_frame_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES     = 320,
    parameter int unsigned V_RES     = 240,
    parameter int unsigned PIX_LAT   = 1,
    parameter int unsigned FRAME_GAP = 0
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  init_data,
    input  logic               init_en,
    input  logic               init_done,
    input  logic               wr_done,
    output logic [WORD_W-1:0]  lcd_data,
    output logic               lcd_en,
    input  logic               run,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    input  logic [7:0]         pix_data,
    output logic               frame_start,
    output logic               frame_done,
    output logic               busy
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_RES - 1);
    localparam int unsigned        CNT_MAX = (FRAME_GAP > PIX_LAT) ? FRAME_GAP : PIX_LAT;
    localparam int unsigned        CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'((PIX_LAT > 0) ? PIX_LAT - 1 : 0);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    state_t                 state, state_nxt;
    logic [CMD_IDX_W-1:0]   cmd_idx, cmd_idx_nxt, rom_idx;
    logic [COORD_W-1:0]     x_nxt, y_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [WORD_W-1:0]      word, word_nxt, rom_word;
    logic                   fs_nxt, fd_nxt, start_frame;

    // Outside CMD the only word ever needed from the ROM is the first one.
    assign rom_idx = (state == S_CMD) ? cmd_idx + CMD_IDX_W'(1) : '0;

    lcd_window_cmd_rom #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_cmd_rom (
        .cmd_idx  (rom_idx),
        .cmd_word (rom_word)
    );

    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            state       <= S_WAIT_INIT;
            cmd_idx     <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            cnt         <= '0;
            word        <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_idx     <= cmd_idx_nxt;
            pix_x       <= x_nxt;
            pix_y       <= y_nxt;
            cnt         <= cnt_nxt;
            word        <= word_nxt;
            frame_start <= fs_nxt;
            frame_done  <= fd_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_idx_nxt = cmd_idx;
        x_nxt       = pix_x;
        y_nxt       = pix_y;
        cnt_nxt     = cnt;
        word_nxt    = word;
        fs_nxt      = 1'b0;
        fd_nxt      = 1'b0;
        start_frame = 1'b0;
        case (state)
            S_WAIT_INIT: if (init_done) state_nxt = S_IDLE;
            S_IDLE:      if (run) start_frame = 1'b1;
            S_CMD: begin
                if (wr_done) begin
                    if (cmd_idx == CMD_LAST) begin
                        state_nxt   = S_PIX_ADDR;
                        cmd_idx_nxt = '0;
                        x_nxt       = '0;
                        y_nxt       = '0;
                    end else begin
                        cmd_idx_nxt = cmd_idx + CMD_IDX_W'(1);
                        word_nxt    = rom_word;
                    end
                end
            end
            S_PIX_ADDR: begin
                if (PIX_LAT == 0) begin
                    state_nxt = S_PIX_SEND;
                    word_nxt  = lcd_word(1'b1, pix_data);
                end else begin
                    state_nxt = S_PIX_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_PIX_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = S_PIX_SEND;
                    word_nxt  = lcd_word(1'b1, pix_data);
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_PIX_SEND: begin
                if (wr_done) begin
                    // Last-pixel test uses the coordinate before it advances.
                    if (pix_x == X_LAST && pix_y == Y_LAST) begin
                        fd_nxt = 1'b1;
                        x_nxt  = '0;
                        y_nxt  = '0;
                        if (FRAME_GAP > 0) begin
                            state_nxt = S_GAP;
                            cnt_nxt   = '0;
                        end else if (run) begin
                            start_frame = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        state_nxt = S_PIX_ADDR;
                        if (pix_x == X_LAST) begin
                            x_nxt = '0;
                            y_nxt = pix_y + COORD_W'(1);
                        end else begin
                            x_nxt = pix_x + COORD_W'(1);
                        end
                    end
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (run) start_frame = 1'b1;
                    else     state_nxt   = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_WAIT_INIT;
        endcase
        // Every frame begins with window word 0 already loaded.
        if (start_frame) begin
            state_nxt   = S_CMD;
            cmd_idx_nxt = '0;
            word_nxt    = rom_word;
            fs_nxt      = 1'b1;
        end
    end

    always_comb begin
        lcd_data = word;
        lcd_en   = (state == S_CMD) || (state == S_PIX_SEND);
        if (state == S_WAIT_INIT) begin
            lcd_data = init_data;
            lcd_en   = init_en;
        end
    end

    assign busy = (state != S_WAIT_INIT) && (state != S_IDLE);

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench: a small 4x2 scheduler with a frame gap and a full-size 320x240 one.
module tb_lcd_frame_scheduler;

    logic clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    logic       rst_n = 1'b0;
    logic [8:0] init_data = 9'h011;
    logic       init_en = 1'b0, init_done = 1'b0;
    logic       run = 1'b0, wr_done = 1'b0, b_run = 1'b0, b_wr_done = 1'b0;
    logic       sel = 1'b0;

    logic [8:0] lcd_data, b_lcd_data, pix_x, pix_y, b_pix_x, b_pix_y;
    logic       lcd_en, b_lcd_en, frame_start, frame_done, busy;
    logic       b_frame_start, b_frame_done, b_busy;
    logic [7:0] pix_data, b_pix_data, p1, b_p1;

    int n_checks = 0;
    int n_err    = 0;
    int fs_cnt = 0, fd_cnt = 0, b_fs_cnt = 0;

    logic [8:0] cmd_small [11];
    logic [8:0] cmd_big   [11];

    lcd_frame_scheduler #(.H_RES(4), .V_RES(2), .PIX_LAT(2), .FRAME_GAP(5)) dut (
        .clk_50MHz(clk_50MHz), .rst_n(rst_n), .init_data(init_data), .init_en(init_en),
        .init_done(init_done), .wr_done(wr_done), .lcd_data(lcd_data), .lcd_en(lcd_en),
        .run(run), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
    );

    lcd_frame_scheduler #(.H_RES(320), .V_RES(240), .PIX_LAT(2), .FRAME_GAP(0)) u_big (
        .clk_50MHz(clk_50MHz), .rst_n(rst_n), .init_data(init_data), .init_en(init_en),
        .init_done(init_done), .wr_done(b_wr_done), .lcd_data(b_lcd_data), .lcd_en(b_lcd_en),
        .run(b_run), .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_data(b_pix_data),
        .frame_start(b_frame_start), .frame_done(b_frame_done), .busy(b_busy)
    );

    // Pixel sources: x^y delivered two cycles after the address.
    always_ff @(posedge clk_50MHz) begin
        p1         <= pix_x[7:0] ^ pix_y[7:0];
        pix_data   <= p1;
        b_p1       <= b_pix_x[7:0] ^ b_pix_y[7:0];
        b_pix_data <= b_p1;
    end

    always_ff @(posedge clk_50MHz) begin
        if (frame_start === 1'b1)   fs_cnt   <= fs_cnt + 1;
        if (frame_done === 1'b1)    fd_cnt   <= fd_cnt + 1;
        if (b_frame_start === 1'b1) b_fs_cnt <= b_fs_cnt + 1;
    end

    logic       c_en;
    logic [8:0] c_data, c_x, c_y;
    assign c_en   = sel ? b_lcd_en   : lcd_en;
    assign c_data = sel ? b_lcd_data : lcd_data;
    assign c_x    = sel ? b_pix_x    : pix_x;
    assign c_y    = sel ? b_pix_y    : pix_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic set_wr(input logic v);
        if (sel) b_wr_done = v;
        else     wr_done   = v;
    endtask

    task automatic pulse_wr();
        set_wr(1'b1);
        tick();
        set_wr(1'b0);
    endtask

    task automatic cmd_words();
        for (int i = 0; i < 11; i++) begin
            chk("cmd_en", 32'(c_en), 32'd1);
            chk($sformatf("cmd_word%0d", i), 32'(c_data), 32'(sel ? cmd_big[i] : cmd_small[i]));
            tick();
            tick();
            pulse_wr();
        end
    endtask

    // Wait out the address/latency phase, then check one pixel word and send it.
    task automatic pixel(input int k, input int h, input bit spur);
        int n;
        int x;
        int y;
        n = 0;
        x = k % h;
        y = k / h;
        if (spur) set_wr(1'b1);
        while (!c_en && n < 20) begin
            tick();
            n++;
        end
        set_wr(1'b0);
        chk($sformatf("pix_gap%0d", k), 32'(n), 32'd3);
        chk($sformatf("pix_x%0d", k), 32'(c_x), 32'(x));
        chk($sformatf("pix_y%0d", k), 32'(c_y), 32'(y));
        chk($sformatf("pix_word%0d", k), 32'(c_data), 32'({1'b1, 8'(x ^ y)}));
        tick();
        tick();
        pulse_wr();
    endtask

    initial begin
        cmd_small = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                      9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
        cmd_big   = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
                      9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C};

        // Reset state and init pass-through
        tick();
        rst_n = 1'b1;
        chk("rst_en", 32'(lcd_en), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'h011);
        chk("rst_x", 32'(pix_x), 32'd0);
        chk("rst_y", 32'(pix_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        init_en = 1'b1;
        #1;
        chk("init_en_hi", 32'(lcd_en), 32'd1);
        tick();
        init_en = 1'b0;
        #1;
        chk("init_en_lo", 32'(lcd_en), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);

        // init_done -> IDLE; pass-through stops, later init_done drop ignored
        init_en   = 1'b1;
        init_done = 1'b1;
        tick();
        chk("idle_en", 32'(lcd_en), 32'd0);
        chk("idle_data", 32'(lcd_data), 32'h000);
        init_done = 1'b0;
        tick();
        chk("idle_drop_en", 32'(lcd_en), 32'd0);
        init_done = 1'b1;
        init_en   = 1'b0;
        pulse_wr();
        chk("idle_spur_busy", 32'(busy), 32'd0);
        chk("idle_spur_x", 32'(pix_x), 32'd0);

        // Frame 1 of the 4x2 design
        run = 1'b1;
        tick();
        chk("fs_pulse", 32'(frame_start), 32'd1);
        chk("cmd_busy", 32'(busy), 32'd1);
        cmd_words();
        chk("fs_single", 32'(frame_start), 32'd0);
        chk("addr_en", 32'(lcd_en), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) run = 1'b0;
            pixel(k, 4, k == 1);
        end
        chk("fd_pulse", 32'(frame_done), 32'd1);
        chk("fd_x", 32'(pix_x), 32'd0);
        chk("fd_y", 32'(pix_y), 32'd0);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("gap_busy%0d", j), 32'(busy), 32'd1);
            chk($sformatf("gap_en%0d", j), 32'(lcd_en), 32'd0);
            if (j == 1) chk("fd_once", 32'(frame_done), 32'd0);
            tick();
        end
        chk("post_gap_busy", 32'(busy), 32'd0);
        tick();
        chk("post_gap_fs", 32'(frame_start), 32'd0);
        chk("fs_count1", 32'(fs_cnt), 32'd1);
        chk("fd_count1", 32'(fd_cnt), 32'd1);

        // Frame 2, reset in the middle of the pixel stream
        run = 1'b1;
        tick();
        cmd_words();
        pixel(0, 4, 1'b0);
        tick();
        chk("mid_x", 32'(pix_x), 32'd1);
        run       = 1'b0;
        rst_n     = 1'b0;
        init_en   = 1'b1;
        init_data = 9'h155;
        tick();
        rst_n = 1'b1;
        chk("mrst_en", 32'(lcd_en), 32'd1);
        chk("mrst_data", 32'(lcd_data), 32'h155);
        chk("mrst_x", 32'(pix_x), 32'd0);
        chk("mrst_y", 32'(pix_y), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_fd", 32'(frame_done), 32'd0);
        tick();
        tick();
        chk("mrst_idle_en", 32'(lcd_en), 32'd0);
        chk("fs_count2", 32'(fs_cnt), 32'd2);
        chk("fd_count2", 32'(fd_cnt), 32'd1);
        init_en = 1'b0;

        // Full-size design: window words and the first row wrap
        sel   = 1'b1;
        b_run = 1'b1;
        tick();
        chk("big_fs", 32'(b_frame_start), 32'd1);
        cmd_words();
        for (int k = 0; k < 322; k++) pixel(k, 320, 1'b0);
        b_run = 1'b0;
        chk("big_end_x", 32'(b_pix_x), 32'd2);
        chk("big_end_y", 32'(b_pix_y), 32'd1);
        chk("big_fs_count", 32'(b_fs_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_frame_scheduler.md
# lcd_frame_scheduler

Frame-level controller that owns the shared `lcd_write` SPI serializer after power-up. It passes the `lcd_init` stream through until `init_done`. It then repeatedly sets the full-screen window (CASET/RASET), issues RAMWR, and streams H_RES×V_RES RGB332 pixels fetched from a pixel source via a coordinate/latency handshake. It replaces the ad-hoc pixel counter that sits in front of `lcd_write` in each display top.

## Interface
Parameters:
- H_RES, 320: pixels per line; 1..512.
- V_RES, 240: lines per frame; 1..512.
- PIX_LAT, 1: cycles from `pix_x`/`pix_y` change to valid `pix_data`; 0..7.
- FRAME_GAP, 0: idle cycles between frames; 0 skips the gap.

Ports:
- clk_50MHz  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- init_data  in  9  word from lcd_init; bit8 = dc.
- init_en  in  1  en_write from lcd_init.
- init_done  in  1  level; init sequence complete.
- wr_done  in  1  one-cycle pulse from lcd_write: current word shifted out.
- lcd_data  out  9  word to lcd_write; bit8 = dc (0 command, 1 data).
- lcd_en  out  1  en_write to lcd_write.
- run  in  1  level; frames repeat while high.
- pix_x  out  9  requested pixel column.
- pix_y  out  9  requested pixel row.
- pix_data  in  8  RGB332 for (pix_x, pix_y), valid PIX_LAT cycles after the address.
- frame_start  out  1  one-cycle pulse on entering CMD.
- frame_done  out  1  one-cycle pulse on the last pixel's wr_done.
- busy  out  1  high in CMD/PIX_*/GAP.

## Operation
States:
- WAIT_INIT:
  - `lcd_data` = `init_data` and `lcd_en` = `init_en`, both combinational pass-through.
  - Moves to IDLE on the first cycle `init_done` = 1.
- IDLE:
  - `lcd_en` = 0.
  - If `run` = 1, moves to CMD and pulses `frame_start`.
- CMD: sends 11 words indexed by cmd_idx 0..10:
  - 0x02A, 0x100, 0x100, {1,(H_RES-1)[15:8]}, {1,(H_RES-1)[7:0]}
  - 0x02B, 0x100, 0x100, {1,(V_RES-1)[15:8]}, {1,(V_RES-1)[7:0]}
  - 0x02C
  - `lcd_en` = 1 throughout. cmd_idx advances on `wr_done`.
  - `wr_done` at idx 10 moves to PIX_ADDR with x = y = 0.
- PIX_ADDR:
  - `lcd_en` = 0.
  - `pix_x`/`pix_y` already hold the current coordinate.
  - Next state is PIX_WAIT if PIX_LAT > 0, otherwise PIX_SEND.
- PIX_WAIT:
  - `lcd_en` = 0.
  - Counts PIX_LAT-1 further cycles, then moves to PIX_SEND.
- PIX_SEND:
  - On entry, `pix_data` is latched into word register {1, pix_data}. `lcd_en` = 1.
  - On `wr_done`: advance x; at x = H_RES-1 wrap x to 0 and increment y.
  - On `wr_done` of pixel (H_RES-1, V_RES-1):
    - pulse `frame_done` and reset x = y = 0;
    - go to GAP if FRAME_GAP > 0;
    - otherwise go to CMD (pulsing `frame_start`) if `run` = 1, else IDLE.
  - Any other `wr_done` returns to PIX_ADDR.
- GAP:
  - Counts FRAME_GAP cycles with `lcd_en` = 0.
  - Then goes to CMD (pulsing `frame_start`) if `run`, else IDLE.

Boundary rules:
- `wr_done` while `lcd_en` = 0 is ignored.
- `run` falling mid-frame: the current frame completes, then IDLE.
- `run` rising in GAP has no effect until the gap ends.
- `init_done` dropping after WAIT_INIT is ignored; only reset re-enters WAIT_INIT.
- Reset mid-frame: next cycle is WAIT_INIT, counters cleared, no `frame_done`.
- H_RES = 1 or V_RES = 1: wrap and last-pixel detection must still hold; a 1×1 frame is one pixel.

## Timing
Reset values (outputs after the reset cycle):
- `lcd_en` = `init_en` and `lcd_data` = `init_data` (pass-through).
- `pix_x` = `pix_y` = 0.
- `frame_start` = `frame_done` = `busy` = 0.
- Internal registers = 0.

Latencies:
- `init_done` → IDLE: 1 cycle.
- IDLE with `run` → `lcd_en` high with 0x02A: 1 cycle.
- `wr_done` → next CMD word on `lcd_data`: 1 cycle; `lcd_en` stays high across CMD words.

Per-pixel overhead beyond the SPI word time:
- 1 + PIX_LAT cycles with `lcd_en` low.
- `pix_x`/`pix_y` update in the cycle after `wr_done` and stay stable until the next `wr_done`.

Pulses:
- `frame_done` is registered, in the cycle after the final `wr_done`.
- `frame_start` is registered, in the first CMD cycle.

Data path:
- `lcd_data` comes from the registered word in every state except WAIT_INIT.
- Coordinates are unsigned 9-bit. Last-pixel compare is x == H_RES-1 && y == V_RES-1, evaluated before increment.

## Structure
- Shared package `lcd_pkg`:
  - LCD_CMD_CASET = 8'h2A, LCD_CMD_RASET = 8'h2B, LCD_CMD_RAMWR = 8'h2C;
  - DC_BIT = 8;
  - state encoding localparams.
- Sub-module `lcd_window_cmd_rom`:
  - combinational, cmd_idx[3:0] plus H_RES/V_RES in, 9-bit word out;
  - index > 10 returns 0x000.
- The top holds the FSM, coordinate counters, latency/gap counter and word register.

## Test plan
- Reset then `init_en` toggling with `init_data` = 0x011 before `init_done` → `lcd_data`/`lcd_en` mirror inputs; `busy` = 0.
- `init_done` = 1, `run` = 1, `wr_done` model = 1 pulse per 18 cycles of `lcd_en` → first 11 words 0x02A,0x100,0x100,0x101,0x13F,0x02B,0x100,0x100,0x100,0x1EF,0x02C; `frame_start` exactly once.
- Source returns `pix_data` = x[7:0]^y[7:0] with PIX_LAT = 2 → pixel word k equals {1, (k%320)^(k/320)} for all 76800; `frame_done` once, after word 76800.
- H_RES = 4, V_RES = 2, FRAME_GAP = 5, `run` dropped during pixel 3 → frame completes with 8 pixels, 5 idle cycles, then IDLE; no second `frame_start`.
- Spurious `wr_done` in PIX_ADDR/PIX_WAIT/IDLE → no coordinate advance and no word skipped.
- `rst_n` = 0 for 1 cycle mid-pixel stream → WAIT_INIT next cycle, `pix_x` = `pix_y` = 0, no `frame_done`.
